// File: rtl/carry_look_ahead_adder.sv
// Two-level carry-lookahead adder with registered {Carry, Sum}.
// Define CLA_INPUT_REG_EN to register A/B/Cin as well, for a latency of 2.
module carry_look_ahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("carry_look_ahead_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             cin_s;

`ifdef CLA_INPUT_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;

  always_comb begin
    a_d   = A;
    b_d   = B;
    cin_d = Cin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  assign a_s   = a_q;
  assign b_s   = b_q;
  assign cin_s = cin_q;
`else
  assign a_s   = A;
  assign b_s   = B;
  assign cin_s = Cin;
`endif

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    pg;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;

  assign p = a_s ^ b_s;
  assign g = a_s & b_s;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] gp;
    logic [3:0] gn;
    logic       ci;

    assign gp = p[4*k +: 4];
    assign gn = g[4*k +: 4];
    assign ci = gc[k];

    // Internal carries are flat SOP terms of the group carry-in.
    assign c[4*k]   = ci;
    assign c[4*k+1] = gn[0]
                    | (gp[0] & ci);
    assign c[4*k+2] = gn[1]
                    | (gp[1] & gn[0])
                    | (gp[1] & gp[0] & ci);
    assign c[4*k+3] = gn[2]
                    | (gp[2] & gn[1])
                    | (gp[2] & gp[1] & gn[0])
                    | (gp[2] & gp[1] & gp[0] & ci);

    assign pg[k] = &gp;
    assign gg[k] = gn[3]
                 | (gp[3] & gn[2])
                 | (gp[3] & gp[2] & gn[1])
                 | (gp[3] & gp[2] & gp[1] & gn[0]);
  end

  assign c[WIDTH] = gc[NG];

  function automatic logic span_and(
    input logic [NG-1:0] v,
    input int            lo,
    input int            hi
  );
    logic r;
    r = 1'b1;
    for (int i = 0; i < NG; i++) begin
      if (i >= lo && i <= hi) r = r & v[i];
    end
    return r;
  endfunction

  // Second level: each group carry-in is a flat SOP of lower PG/GG and Cin.
  always_comb begin
    gc    = '0;
    gc[0] = cin_s;
    for (int k = 1; k <= NG; k++) begin
      gc[k] = cin_s & span_and(pg, 0, k - 1);
      for (int j = 0; j < k; j++) begin
        gc[k] = gc[k] | (gg[j] & span_and(pg, j + 1, k - 1));
      end
    end
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;

  assign sum_d   = p ^ c[WIDTH-1:0];
  assign carry_d = c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Bench for carry_look_ahead_adder at WIDTH 4 and 16.
// Latency follows CLA_INPUT_REG_EN (2 when defined, else 1).
module tb_carry_look_ahead_adder;

`ifdef CLA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a4, b4, s4;
  logic        ci4, co4;
  logic [15:0] a16, b16, s16;
  logic        ci16, co16;

  int n_tests = 0;
  int n_fail  = 0;

  carry_look_ahead_adder #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .A    (a4),
    .B    (b4),
    .Cin  (ci4),
    .Sum  (s4),
    .Carry(co4)
  );

  carry_look_ahead_adder #(.WIDTH(16)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .A    (a16),
    .B    (b16),
    .Cin  (ci16),
    .Sum  (s16),
    .Carry(co16)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       carry;
  } vec_t;

  vec_t        tbl[6];
  logic [4:0]  q4[$];
  logic [16:0] q16[$];

  task automatic check(input string nm, input logic [16:0] act,
                       input logic [16:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick4(input string nm);
    @(posedge clk);
    #1;
    if (q4.size() == LAT) check(nm, {12'd0, co4, s4}, {12'd0, q4.pop_front()});
  endtask

  task automatic flush4(input string nm);
    while (q4.size() > 0) begin
      @(posedge clk);
      #1;
      check(nm, {12'd0, co4, s4}, {12'd0, q4.pop_front()});
    end
  endtask

  task automatic tick16();
    @(posedge clk);
    #1;
    if (q16.size() == LAT) check("rand16", {co16, s16}, q16.pop_front());
  endtask

  task automatic flush16();
    while (q16.size() > 0) begin
      @(posedge clk);
      #1;
      check("rand16", {co16, s16}, q16.pop_front());
    end
  endtask

  initial begin
    longint ref16;

    tbl[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0};
    tbl[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
    tbl[2] = '{4'b1110, 4'b1111, 1'b1, 4'b1110, 1'b1};
    tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[5] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1};

    rst  = 1'b1;
    a4   = 4'hf;
    b4   = 4'hf;
    ci4  = 1'b1;
    a16  = 16'hffff;
    b16  = 16'hffff;
    ci16 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset4", {12'd0, co4, s4}, 17'd0);
      check("reset16", {co16, s16}, 17'd0);
    end

    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a4  = tbl[i].a;
      b4  = tbl[i].b;
      ci4 = tbl[i].cin;
      q4.push_back({tbl[i].carry, tbl[i].sum});
      tick4("table4");
    end
    flush4("table4");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4  = 4'(a);
          b4  = 4'(b);
          ci4 = 1'(c);
          q4.push_back(5'(a + b + c));
          tick4("exh4");
        end
      end
    end
    flush4("exh4");

    // Output now holds 15+15+1; reset must clear it on the next edge.
    rst = 1'b1;
    a4  = 4'hf;
    b4  = 4'hf;
    ci4 = 1'b1;
    @(posedge clk);
    #1;
    check("rst_enter", {12'd0, co4, s4}, 17'd0);
    @(posedge clk);
    #1;
    check("rst_hold", {12'd0, co4, s4}, 17'd0);

    rst = 1'b0;
    a4  = 4'b0011;
    b4  = 4'b0101;
    ci4 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_exit_e1", {12'd0, co4, s4}, (LAT == 1) ? 17'd8 : 17'd0);
    @(posedge clk);
    #1;
    check("rst_exit_e2", {12'd0, co4, s4}, 17'd8);

    for (int i = 0; i < 10000; i++) begin
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      ci16 = 1'($urandom);
      ref16 = longint'(a16) + longint'(b16) + longint'(ci16);
      q16.push_back(17'(ref16));
      tick16();
    end
    a16  = 16'hffff;
    b16  = 16'h0000;
    ci16 = 1'b1;
    q16.push_back(17'h10000);
    tick16();
    flush16();

    rst  = 1'b1;
    a16  = 16'hffff;
    b16  = 16'hffff;
    ci16 = 1'b1;
    @(posedge clk);
    #1;
    check("rst16", {co16, s16}, 17'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
